// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared constants and types for the RV32IM core control
//                blocks (hazard control state encoding, register x0 index).
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Hazard control unit state encoding
    typedef enum logic [1:0] {
        HCU_IDLE     = 2'd0,
        HCU_DIV_WAIT = 2'd1,
        HCU_DIV_DONE = 2'd2
    } hcu_state_t;

    // Architectural zero register; never a real producer
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default EX-stage occupancy of a divide, including its completion cycle
    localparam int DEFAULT_DIV_CYCLES = 33;

endpackage : core_pkg
`default_nettype wire

// File: rtl/hcu_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hcu_sat_counter
//  Description : Parameterised saturating event counter. Counts one per
//                cycle while inc is high and sticks at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module hcu_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_max = '1;

    logic [WIDTH-1:0] r_count;

    // Count events, holding at the maximum value instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule : hcu_sat_counter
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_unit
//  Description : Pipeline hazard and stall controller for the 5-stage RV32IM
//                core. Inserts load-use bubbles, freezes the pipe while a
//                multi-cycle divide occupies EX, flushes on taken branches and
//                keeps a saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit
    import core_pkg::*;
#(
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES,
    parameter int PERF_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [4:0]            ID_RS1,
    input  logic [4:0]            ID_RS2,
    input  logic                  ID_USES_RS1,
    input  logic                  ID_USES_RS2,
    input  logic [4:0]            EX_RD,
    input  logic                  EX_MEM_READ,
    input  logic                  EX_IS_DIV,
    input  logic                  BRANCH_TAKEN,
    output logic                  PC_WRITE_EN,
    output logic                  IF_ID_WRITE_EN,
    output logic                  IF_ID_FLUSH,
    output logic                  ID_EX_WRITE_EN,
    output logic                  ID_EX_FLUSH,
    output logic                  EX_MEM_BUBBLE,
    output logic                  MDU_START,
    output logic [PERF_WIDTH-1:0] STALL_COUNT
);

    // Wait-state count loaded on the start cycle: start cycle plus this many
    // wait cycles gives DIV_CYCLES-1 frozen cycles before the done cycle.
    localparam logic [7:0] c_div_load = 8'(DIV_CYCLES - 2);
    localparam logic [7:0] c_one      = 8'd1;

    hcu_state_t r_state;
    hcu_state_t w_state_next;
    logic [7:0] r_div_cnt;
    logic [7:0] w_div_cnt_next;
    logic       w_load_use;

    // Load-use hazard: a load in EX produces a register the ID instruction reads
    assign w_load_use = EX_MEM_READ && (EX_RD != REG_ZERO) &&
                        ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                         (ID_USES_RS2 && (ID_RS2 == EX_RD)));

    // State and divide-counter registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= HCU_IDLE;
            r_div_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_next;
            r_div_cnt <= w_div_cnt_next;
        end
    end

    // Next-state and pipeline control outputs
    always_comb begin
        w_state_next   = r_state;
        w_div_cnt_next = r_div_cnt;
        PC_WRITE_EN    = 1'b1;
        IF_ID_WRITE_EN = 1'b1;
        IF_ID_FLUSH    = 1'b0;
        ID_EX_WRITE_EN = 1'b1;
        ID_EX_FLUSH    = 1'b0;
        EX_MEM_BUBBLE  = 1'b0;
        MDU_START      = 1'b0;

        case (r_state)
            HCU_IDLE: begin
                if (EX_IS_DIV) begin
                    // Divide takes priority; freeze everything upstream of EX
                    MDU_START      = 1'b1;
                    PC_WRITE_EN    = 1'b0;
                    IF_ID_WRITE_EN = 1'b0;
                    ID_EX_WRITE_EN = 1'b0;
                    EX_MEM_BUBBLE  = 1'b1;
                    w_div_cnt_next = c_div_load;
                    // A two-cycle divide has no wait cycles at all
                    w_state_next   = (c_div_load == 8'd0) ? HCU_DIV_DONE : HCU_DIV_WAIT;
                end else if (BRANCH_TAKEN) begin
                    IF_ID_FLUSH = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                end else if (w_load_use) begin
                    // Hold PC and IF/ID one cycle, push a bubble into ID/EX
                    PC_WRITE_EN    = 1'b0;
                    IF_ID_WRITE_EN = 1'b0;
                    ID_EX_FLUSH    = 1'b1;
                end
            end
            HCU_DIV_WAIT: begin
                // EX still owns the divide: branch and load-use are ignored
                PC_WRITE_EN    = 1'b0;
                IF_ID_WRITE_EN = 1'b0;
                ID_EX_WRITE_EN = 1'b0;
                EX_MEM_BUBBLE  = 1'b1;
                w_div_cnt_next = r_div_cnt - c_one;
                if (r_div_cnt <= c_one) begin
                    w_state_next = HCU_DIV_DONE;
                end
            end
            HCU_DIV_DONE: begin
                // Result moves to EX/MEM; EX_IS_DIV is still high but stale
                w_state_next = HCU_IDLE;
            end
            default: begin
                w_state_next = HCU_IDLE;
            end
        endcase

        // Reset forces a free-running, flush-free pipeline
        if (RESET) begin
            PC_WRITE_EN    = 1'b1;
            IF_ID_WRITE_EN = 1'b1;
            IF_ID_FLUSH    = 1'b0;
            ID_EX_WRITE_EN = 1'b1;
            ID_EX_FLUSH    = 1'b0;
            EX_MEM_BUBBLE  = 1'b0;
            MDU_START      = 1'b0;
        end
    end

    // Every cycle with PC held counts as a stall; flushes do not hold PC
    hcu_sat_counter #(
        .WIDTH (PERF_WIDTH)
    ) u_stall_counter (
        .clk   (CLK),
        .rst   (RESET),
        .inc   (~PC_WRITE_EN),
        .count (STALL_COUNT)
    );

    // A divide and a taken branch can never both be presented to EX
    a_div_branch_exclusive: assert property (
        @(posedge CLK) disable iff (RESET) !(EX_IS_DIV && BRANCH_TAKEN)
    );

endmodule : hazard_control_unit
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_control_unit
//  Description : Self-checking bench for hazard_control_unit: table-driven
//                single-cycle hazard vectors plus divide, back-to-back divide,
//                reset-mid-divide and counter saturation sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

    localparam int PW = 7;
    localparam int CNT_MAX = (1 << PW) - 1;

    // {PC_WE, IF_ID_WE, IF_ID_FLUSH, ID_EX_WE, ID_EX_FLUSH, EX_MEM_BUBBLE, MDU_START}
    localparam logic [6:0] O_NORMAL = 7'b1101000;
    localparam logic [6:0] O_LDUSE  = 7'b0001100;
    localparam logic [6:0] O_BRANCH = 7'b1111100;
    localparam logic [6:0] O_DSTART = 7'b0000011;
    localparam logic [6:0] O_DWAIT  = 7'b0000010;

    logic          clk;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_div, branch_taken;
    logic          pc_we, ifid_we, ifid_fl, idex_we, idex_fl, bubble, mdu_start;
    logic [PW-1:0] stall_count;
    logic [6:0]    outs;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] exrd;
        logic       memrd;
        logic       br;
        logic [6:0] exp_outs;
        logic       stall;
    } vec_t;

    vec_t vecs[10];

    hazard_control_unit #(
        .DIV_CYCLES (33),
        .PERF_WIDTH (PW)
    ) dut (
        .CLK            (clk),
        .RESET          (rst),
        .ID_RS1         (id_rs1),
        .ID_RS2         (id_rs2),
        .ID_USES_RS1    (id_uses_rs1),
        .ID_USES_RS2    (id_uses_rs2),
        .EX_RD          (ex_rd),
        .EX_MEM_READ    (ex_mem_read),
        .EX_IS_DIV      (ex_is_div),
        .BRANCH_TAKEN   (branch_taken),
        .PC_WRITE_EN    (pc_we),
        .IF_ID_WRITE_EN (ifid_we),
        .IF_ID_FLUSH    (ifid_fl),
        .ID_EX_WRITE_EN (idex_we),
        .ID_EX_FLUSH    (idex_fl),
        .EX_MEM_BUBBLE  (bubble),
        .MDU_START      (mdu_start),
        .STALL_COUNT    (stall_count)
    );

    assign outs = {pc_we, ifid_we, ifid_fl, idex_we, idex_fl, bubble, mdu_start};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] exrd,
                                 input logic memrd, input logic br,
                                 input logic [6:0] eo, input logic st);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exrd = exrd;
        v.memrd = memrd; v.br = br; v.exp_outs = eo; v.stall = st;
        return v;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_is_div = 1'b0; branch_taken = 1'b0;
    endtask

    // Reset while a load-use hazard is presented: outputs must be forced
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        id_rs2 = 5'd5; id_uses_rs2 = 1'b1; ex_rd = 5'd5; ex_mem_read = 1'b1;
        #2;
        chk("reset_outputs", 32'(outs), 32'(O_NORMAL));
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #2;
        exp_cnt = 0;
        chk("reset_count", 32'(stall_count), 32'(exp_cnt));
        chk("post_reset_outputs", 32'(outs), 32'(O_NORMAL));
    endtask

    // Hold EX_IS_DIV for n back-to-back 33-cycle divides, checking every cycle
    task automatic run_divs(input int n, input string name);
        for (int k = 0; k < 33 * n; k++) begin
            int m;
            logic [6:0] e;
            @(negedge clk);
            clear_inputs();
            ex_is_div = 1'b1;
            // Hazard inputs present during the wait must be ignored
            if ((k % 33) == 5) begin
                id_rs1 = 5'd9; id_uses_rs1 = 1'b1; ex_rd = 5'd9; ex_mem_read = 1'b1;
            end
            #2;
            m = k % 33;
            e = (m == 0) ? O_DSTART : ((m == 32) ? O_NORMAL : O_DWAIT);
            chk(name, 32'(outs), 32'(e));
            if (m != 32) exp_cnt = sat_inc(exp_cnt);
        end
        @(negedge clk);
        clear_inputs();
        #2;
        chk({name, "_count"}, 32'(stall_count), 32'(exp_cnt));
        chk({name, "_idle"}, 32'(outs), 32'(O_NORMAL));
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        vecs[0] = mkv(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, O_NORMAL, 1'b0);
        vecs[1] = mkv(5'd1,  5'd5,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, O_LDUSE,  1'b1);
        vecs[2] = mkv(5'd7,  5'd2,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, O_LDUSE,  1'b1);
        vecs[3] = mkv(5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, O_NORMAL, 1'b0);
        vecs[4] = mkv(5'd7,  5'd3,  1'b0, 1'b1, 5'd7,  1'b1, 1'b0, O_NORMAL, 1'b0);
        vecs[5] = mkv(5'd7,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, O_NORMAL, 1'b0);
        vecs[6] = mkv(5'd5,  5'd5,  1'b1, 1'b1, 5'd5,  1'b1, 1'b1, O_BRANCH, 1'b0);
        vecs[7] = mkv(5'd3,  5'd4,  1'b1, 1'b1, 5'd6,  1'b0, 1'b1, O_BRANCH, 1'b0);
        vecs[8] = mkv(5'd3,  5'd4,  1'b1, 1'b1, 5'd6,  1'b1, 1'b0, O_NORMAL, 1'b0);
        vecs[9] = mkv(5'd1,  5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, O_LDUSE,  1'b1);

        do_reset();

        // Single-cycle hazard vectors
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clear_inputs();
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_rd = vecs[i].exrd; ex_mem_read = vecs[i].memrd; branch_taken = vecs[i].br;
            #2;
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp_outs));
            chk($sformatf("vec%0d_count", i), 32'(stall_count), 32'(exp_cnt));
            if (vecs[i].stall) exp_cnt = sat_inc(exp_cnt);
        end
        @(negedge clk);
        clear_inputs();
        #2;
        chk("vec_final_count", 32'(stall_count), 32'(exp_cnt));

        // Single divide, then back-to-back divides
        do_reset();
        run_divs(1, "div1");
        do_reset();
        run_divs(2, "div2");

        // Reset in frozen cycle 10 of a divide
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            clear_inputs();
            ex_is_div = 1'b1;
            #2;
            chk("abort_pre", 32'(outs), 32'((k == 0) ? O_DSTART : O_DWAIT));
            exp_cnt = sat_inc(exp_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("abort_reset_outs", 32'(outs), 32'(O_NORMAL));
        chk("abort_pre_count", 32'(stall_count), 32'(exp_cnt));
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #2;
        exp_cnt = 0;
        chk("abort_idle_outs", 32'(outs), 32'(O_NORMAL));
        chk("abort_count", 32'(stall_count), 32'(exp_cnt));
        run_divs(1, "div_after_abort");

        // Drive the counter past its maximum: 32 + 96 stalls saturate at 127
        run_divs(3, "div_sat");
        chk("sat_value", 32'(stall_count), 32'(CNT_MAX));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hazard_control_unit
`default_nettype wire
